// File: rtl/hazard_ctrl_if.sv
// D-stage instruction descriptor and hazard decision outputs between the
// decode front end and the hazard controller.
interface hazard_ctrl_if;
    logic       d_valid;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic [1:0] d_tuse_rs;
    logic [1:0] d_tuse_rt;
    logic [4:0] d_wreg;
    logic [1:0] d_tnew;
    logic       d_md_start;
    logic       d_md_div;
    logic       d_md_use;
    logic       stall;
    logic       flush_e;
    logic       md_busy;

    modport master (
        output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wreg, d_tnew,
               d_md_start, d_md_div, d_md_use,
        input  stall, flush_e, md_busy
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wreg, d_tnew,
               d_md_start, d_md_div, d_md_use,
        output stall, flush_e, md_busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/bubble decision for the five-stage core: tracks destination and
// result latency of the E and M instructions and sequences the mult/div unit.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);
    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);
    localparam logic [1:0] TUSE_NONE = 2'd3;

    logic [4:0] e_wreg, m_wreg;
    logic [1:0] e_tnew, m_tnew;
    logic       e_md, e_div;
    logic [3:0] md_cnt;

    logic [4:0] q_wreg;
    logic [1:0] q_tnew, q_tuse_rs, q_tuse_rt;
    logic       q_md_start, q_md_div, q_md_use;
    logic       rs_hazard, rt_hazard, md_hazard, stall;

    function automatic logic src_hazard(
        input logic [4:0] src,  input logic [1:0] tuse,
        input logic [4:0] ew,   input logic [1:0] et,
        input logic [4:0] mw,   input logic [1:0] mt
    );
        return (src != 5'd0) && (tuse != TUSE_NONE) &&
               (((ew == src) && (et > tuse)) || ((mw == src) && (mt > tuse)));
    endfunction

    // A bubble in D looks like an instruction that reads nothing and writes $0.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        q_wreg     = '0;
        q_tnew     = '0;
        q_tuse_rs  = TUSE_NONE;
        q_tuse_rt  = TUSE_NONE;
        q_md_start = 1'b0;
        q_md_div   = 1'b0;
        q_md_use   = 1'b0;
        if (hz.d_valid) begin
            q_wreg     = hz.d_wreg;
            q_tnew     = hz.d_tnew;
            q_tuse_rs  = hz.d_tuse_rs;
            q_tuse_rt  = hz.d_tuse_rt;
            q_md_start = hz.d_md_start;
            q_md_div   = hz.d_md_div;
            q_md_use   = hz.d_md_use;
        end
    end

    always_comb begin
        rs_hazard = src_hazard(hz.d_rs, q_tuse_rs, e_wreg, e_tnew, m_wreg, m_tnew);
        rt_hazard = src_hazard(hz.d_rt, q_tuse_rt, e_wreg, e_tnew, m_wreg, m_tnew);
        md_hazard = q_md_use && ((md_cnt != 4'd0) || e_md);
        stall     = rs_hazard || rt_hazard || md_hazard;
    end

    assign hz.stall   = stall;
    assign hz.flush_e = stall;
    assign hz.md_busy = (md_cnt != 4'd0);

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every stage
        // advances from the pre-edge values of its neighbours.
        if (reset) begin
            e_wreg <= '0;
            e_tnew <= '0;
            e_md   <= 1'b0;
            e_div  <= 1'b0;
            m_wreg <= '0;
            m_tnew <= '0;
            md_cnt <= '0;
        end else begin
            m_wreg <= e_wreg;
            m_tnew <= (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;
            if (stall) begin
                e_wreg <= '0;
                e_tnew <= '0;
                e_md   <= 1'b0;
                e_div  <= 1'b0;
            end else begin
                e_wreg <= q_wreg;
                e_tnew <= q_tnew;
                e_md   <= q_md_start;
                e_div  <= q_md_div;
            end
            // The busy count starts as the mult/div leaves E.
            if (e_md)
                md_cnt <= e_div ? DIV_LOAD : MULT_LOAD;
            else if (md_cnt != 4'd0)
                md_cnt <= md_cnt - 4'd1;
        end
    end
endmodule
